// File: rtl/shift_div_if.sv
// Request/result bundle for the shift_div restoring divider.
// The master side launches a division and reads back the registered results;
// the slave side is the divider itself.
interface shift_div_if #(
   parameter int WIDTH = 32
);

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;
   logic             div_zero;

   modport master (
      output start,
      output dividend,
      output divisor,
      input  quotient,
      input  remainder,
      input  busy,
      input  done,
      input  div_zero
   );

   modport slave (
      input  start,
      input  dividend,
      input  divisor,
      output quotient,
      output remainder,
      output busy,
      output done,
      output div_zero
   );

endinterface

// File: rtl/shift_div.sv
// shift_div: sequential radix-2 restoring divider, one quotient bit per clock.
// A start accepted in IDLE runs 32 ITER cycles followed by one FIX cycle that
// applies sign correction and registers the results with a one-cycle done.
// A zero divisor skips ITER and reports all-ones / raw dividend with div_zero.
// Optional feature macro: SHIFT_DIV_SIGNED_EN selects two's-complement operands;
// when it is undefined the operands are unsigned and no sign logic exists.
module shift_div #(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   shift_div_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // Working registers: the dividend shifts out of the top of work while the
   // quotient bits shift in at the bottom, so one register serves both.
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] part_rem;
   logic [WIDTH-1:0] div_mag;
   logic [4:0]       count;
   logic             q_neg;
   logic             r_neg;
   logic             zero_flag;

   // Registered results held between operations.
   logic [WIDTH-1:0] quotient_r;
   logic [WIDTH-1:0] remainder_r;
   logic             done_r;
   logic             div_zero_r;

   // Operand conditioning at accept.
   logic             dividend_neg;
   logic             divisor_neg;
   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_mag;
   logic             divisor_is_zero;
   logic             accept;

   // Iteration datapath.
   logic [WIDTH:0]   trial;
   logic [WIDTH+1:0] diff;
   logic             trial_fits;
   logic [WIDTH-1:0] rem_next;
   logic             unused_guard;

   assign divisor_is_zero = (bus.divisor == '0);
   assign accept          = (state == IDLE) && bus.start;

   // Take operand magnitudes and signs; in the unsigned build the raw
   // operands are the magnitudes and the sign flags are constant zero.
   always_comb begin
`ifdef SHIFT_DIV_SIGNED_EN
      dividend_neg = bus.dividend[WIDTH-1];
      divisor_neg  = bus.divisor[WIDTH-1];
      dividend_mag = dividend_neg ? (~bus.dividend + 1'b1) : bus.dividend;
      divisor_mag  = divisor_neg  ? (~bus.divisor  + 1'b1) : bus.divisor;
`else
      dividend_neg = 1'b0;
      divisor_neg  = 1'b0;
      dividend_mag = bus.dividend;
      divisor_mag  = bus.divisor;
`endif
   end

   // Trial subtraction of the divisor magnitude from the shifted partial
   // remainder; a clear top bit of the difference means the divisor fitted.
   always_comb begin
      trial        = {part_rem, work[WIDTH-1]};
      diff         = {1'b0, trial} - {2'b00, div_mag};
      trial_fits   = ~diff[WIDTH+1];
      rem_next     = trial_fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      unused_guard = diff[WIDTH];
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state selection: a zero divisor bypasses the iterations entirely.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next = divisor_is_zero ? FIX : ITER;
            end
         end
         ITER: begin
            if (count == 5'd0) begin
               state_next = FIX;
            end
         end
         FIX: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Busy is a pure function of state, so it drops on the same edge that
   // raises done and the two are never high together.
   always_comb begin
      bus.busy = (state != IDLE);
   end

   // Datapath: capture on accept, one restoring step per ITER cycle, and
   // sign correction plus result registration in FIX.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         work        <= '0;
         part_rem    <= '0;
         div_mag     <= '0;
         count       <= 5'd0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         zero_flag   <= 1'b0;
         quotient_r  <= '0;
         remainder_r <= '0;
         done_r      <= 1'b0;
         div_zero_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  work       <= divisor_is_zero ? bus.dividend : dividend_mag;
                  div_mag    <= divisor_mag;
                  part_rem   <= '0;
                  count      <= 5'd31;
                  q_neg      <= dividend_neg ^ divisor_neg;
                  r_neg      <= dividend_neg;
                  zero_flag  <= divisor_is_zero;
                  div_zero_r <= 1'b0;
               end
            end
            ITER: begin
               part_rem <= rem_next;
               work     <= {work[WIDTH-2:0], trial_fits};
               count    <= count - 5'd1;
            end
            FIX: begin
               if (zero_flag) begin
                  quotient_r  <= '1;
                  remainder_r <= work;
                  div_zero_r  <= 1'b1;
               end else begin
                  quotient_r  <= q_neg ? (~work + 1'b1) : work;
                  remainder_r <= r_neg ? (~part_rem + 1'b1) : part_rem;
               end
               done_r <= 1'b1;
            end
            default: begin
               done_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.quotient  = quotient_r;
   assign bus.remainder = remainder_r;
   assign bus.done      = done_r;
   assign bus.div_zero  = div_zero_r;

endmodule
